// File: rtl/nx_indirect_mem_arb_pkg.sv
// Shared types for the indirect-access RAM arbiter.
// Read-return source and per-cycle arbiter decision.
package nx_indirect_mem_arb_pkg;

  typedef enum logic [1:0] {
    RS_NONE,
    RS_SW,
    RS_HW
  } rd_src_e;

  typedef enum logic [1:0] {
    DEC_NONE,
    DEC_SW,
    DEC_HW
  } arb_dec_e;

endpackage

// File: rtl/nx_indirect_mem_arb_if.sv
// Bus bundle between SW controller, HW engine and the external RAM.
// slave = arbiter view, master = requester/RAM side.
interface nx_indirect_mem_arb_if #(
  parameter int N_ADDR_BITS = 9,
  parameter int N_DATA_BITS = 96
);

  logic                   sw_cs;
  logic                   sw_we;
  logic [N_ADDR_BITS-1:0] sw_add;
  logic [N_DATA_BITS-1:0] sw_wdat;
  logic                   sw_yield;
  logic                   sw_reset;
  logic                   grant;
  logic [N_DATA_BITS-1:0] sw_rdat;

  logic                   hw_req;
  logic                   hw_we;
  logic [N_ADDR_BITS-1:0] hw_add;
  logic [N_DATA_BITS-1:0] hw_wdat;
  logic                   hw_ack;
  logic                   hw_rvalid;
  logic [N_DATA_BITS-1:0] hw_rdat;

  logic                   mem_cs;
  logic                   mem_we;
  logic [N_ADDR_BITS-1:0] mem_add;
  logic [N_DATA_BITS-1:0] mem_wdat;
  logic [N_DATA_BITS-1:0] mem_rdat;

  modport slave (
    input  sw_cs, sw_we, sw_add, sw_wdat,
    input  sw_yield, sw_reset,
    output grant, sw_rdat,
    input  hw_req, hw_we, hw_add, hw_wdat,
    output hw_ack, hw_rvalid, hw_rdat,
    output mem_cs, mem_we, mem_add, mem_wdat,
    input  mem_rdat
  );

  modport master (
    output sw_cs, sw_we, sw_add, sw_wdat,
    output sw_yield, sw_reset,
    input  grant, sw_rdat,
    output hw_req, hw_we, hw_add, hw_wdat,
    input  hw_ack, hw_rvalid, hw_rdat,
    input  mem_cs, mem_we, mem_add, mem_wdat,
    output mem_rdat
  );

endinterface

// File: rtl/nx_indirect_mem_arb.sv
// Single-port RAM arbiter between SW indirect access and HW engine.
// Same-cycle acceptance; read data returned one cycle later.
import nx_indirect_mem_arb_pkg::*;

module nx_indirect_mem_arb #(
  parameter int N_ADDR_BITS  = 9,
  parameter int N_DATA_BITS  = 96,
  parameter int MAX_HW_BURST = 8
) (
  input  logic clk,
  input  logic rst_n,
  nx_indirect_mem_arb_if.slave bus
);

  localparam logic [7:0] BURST_MAX = 8'(MAX_HW_BURST);

  arb_dec_e               dec;
  rd_src_e                rd_src;
  rd_src_e                rd_src_nxt;
  logic [7:0]             burst_cnt;
  logic [7:0]             burst_nxt;
  logic [N_DATA_BITS-1:0] hold_q;
  logic                   sw_win;
  logic                   hw_win;

  // Outputs are forced idle while reset is held.
  always_comb begin
    dec = DEC_NONE;
    if (!rst_n) begin
      dec = DEC_NONE;
    end else if (bus.sw_cs &&
                 (bus.sw_reset || bus.sw_yield ||
                  burst_cnt == BURST_MAX)) begin
      dec = DEC_SW;
    end else if (bus.hw_req && !bus.sw_reset) begin
      dec = DEC_HW;
    end else if (bus.sw_cs) begin
      dec = DEC_SW;
    end
  end

  assign sw_win = (dec == DEC_SW);
  assign hw_win = (dec == DEC_HW);

  assign bus.grant  = sw_win;
  assign bus.hw_ack = hw_win;
  assign bus.mem_cs = sw_win | hw_win;

  always_comb begin
    bus.mem_we   = 1'b0;
    bus.mem_add  = '0;
    bus.mem_wdat = '0;
    unique case (1'b1)
      sw_win: begin
        bus.mem_we   = bus.sw_we;
        bus.mem_add  = bus.sw_add;
        bus.mem_wdat = bus.sw_wdat;
      end
      hw_win: begin
        bus.mem_we   = bus.hw_we;
        bus.mem_add  = bus.hw_add;
        bus.mem_wdat = bus.hw_wdat;
      end
      default: ;
    endcase
  end

  always_comb begin
    burst_nxt  = burst_cnt;
    rd_src_nxt = RS_NONE;
    if (!bus.sw_cs || sw_win) begin
      burst_nxt = '0;
    end else if (hw_win && burst_cnt < BURST_MAX) begin
      burst_nxt = burst_cnt + 8'd1;
    end
    if (sw_win && !bus.sw_we) begin
      rd_src_nxt = RS_SW;
    end else if (hw_win && !bus.hw_we) begin
      rd_src_nxt = RS_HW;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst_cnt <= '0;
      rd_src    <= RS_NONE;
      hold_q    <= '0;
    end else begin
      burst_cnt <= burst_nxt;
      rd_src    <= rd_src_nxt;
      if (rd_src == RS_SW) begin
        hold_q <= bus.mem_rdat;
      end
    end
  end

  assign bus.hw_rvalid = (rd_src == RS_HW);
  assign bus.hw_rdat   = bus.hw_rvalid ? bus.mem_rdat : '0;
  assign bus.sw_rdat   = (rd_src == RS_SW) ? bus.mem_rdat : hold_q;

endmodule

// File: tb/tb_nx_indirect_mem_arb.sv
// Directed bench for nx_indirect_mem_arb with a behavioural
// one-cycle-latency RAM.
module tb_nx_indirect_mem_arb;

  localparam int AW = 9;
  localparam int DW = 96;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  logic [DW-1:0] ram [512];

  nx_indirect_mem_arb_if #(.N_ADDR_BITS(AW), .N_DATA_BITS(DW)) bus ();

  nx_indirect_mem_arb #(
    .N_ADDR_BITS (AW),
    .N_DATA_BITS (DW),
    .MAX_HW_BURST(8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.mem_cs) begin
      if (bus.mem_we) ram[bus.mem_add] <= bus.mem_wdat;
      else bus.mem_rdat <= ram[bus.mem_add];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.sw_cs    = 1'b0;
    bus.sw_we    = 1'b0;
    bus.sw_add   = '0;
    bus.sw_wdat  = '0;
    bus.sw_yield = 1'b0;
    bus.sw_reset = 1'b0;
    bus.hw_req   = 1'b0;
    bus.hw_we    = 1'b0;
    bus.hw_add   = '0;
    bus.hw_wdat  = '0;
  endtask

  task automatic test_reset();
    bus.sw_cs  = 1'b1;
    bus.sw_we  = 1'b1;
    bus.sw_add = 9'd1;
    bus.hw_req = 1'b1;
    bus.hw_add = 9'd2;
    #2;
    n_checks++;
    if (bus.grant !== 1'b0 || bus.hw_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_acc: grant=%b hw_ack=%b want 0 0",
               bus.grant, bus.hw_ack);
    end
    n_checks++;
    if (bus.mem_cs !== 1'b0 || bus.mem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mem: cs=%b we=%b want 0 0",
               bus.mem_cs, bus.mem_we);
    end
    n_checks++;
    if (bus.mem_add !== '0 || bus.mem_wdat !== '0) begin
      n_fail++;
      $display("FAIL reset_bus: add=%h wdat=%h want 0",
               bus.mem_add, bus.mem_wdat);
    end
    n_checks++;
    if (bus.hw_rvalid !== 1'b0 || bus.hw_rdat !== '0 ||
        bus.sw_rdat !== '0) begin
      n_fail++;
      $display("FAIL reset_rd: rv=%b hw=%h sw=%h want 0",
               bus.hw_rvalid, bus.hw_rdat, bus.sw_rdat);
    end
    idle();
    tick();
    rst_n = 1'b1;
  endtask

  // First cycle after release also preloads RAM via HW and SW writes.
  task automatic test_first_cycle();
    bus.hw_req  = 1'b1;
    bus.hw_we   = 1'b1;
    bus.hw_add  = 9'd7;
    bus.hw_wdat = 96'h777;
    #1;
    n_checks++;
    if (bus.hw_ack !== 1'b1 || bus.mem_cs !== 1'b1) begin
      n_fail++;
      $display("FAIL first_cycle: ack=%b cs=%b want 1 1",
               bus.hw_ack, bus.mem_cs);
    end
    tick();
    idle();
    bus.sw_cs   = 1'b1;
    bus.sw_we   = 1'b1;
    bus.sw_add  = 9'd9;
    bus.sw_wdat = 96'h999;
    #1;
    n_checks++;
    if (bus.grant !== 1'b1 || bus.hw_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL sw_wr9: grant=%b ack=%b want 1 0",
               bus.grant, bus.hw_ack);
    end
    tick();
    bus.sw_add  = 9'd5;
    bus.sw_wdat = 96'hA5;
    #1;
    n_checks++;
    if (bus.mem_we !== 1'b1 || bus.mem_add !== 9'd5 ||
        bus.mem_wdat !== 96'hA5) begin
      n_fail++;
      $display("FAIL sw_wr5: we=%b add=%h wdat=%h want 1 5 a5",
               bus.mem_we, bus.mem_add, bus.mem_wdat);
    end
    tick();
    idle();
    #1;
    n_checks++;
    if (bus.sw_rdat !== '0) begin
      n_fail++;
      $display("FAIL sw_wr_rdat: got %h want 0", bus.sw_rdat);
    end
    tick();
  endtask

  task automatic test_sw_read();
    bus.sw_cs  = 1'b1;
    bus.sw_we  = 1'b0;
    bus.sw_add = 9'd5;
    #1;
    n_checks++;
    if (bus.grant !== 1'b1 || bus.mem_we !== 1'b0 ||
        bus.mem_add !== 9'd5) begin
      n_fail++;
      $display("FAIL sw_rd_grant: g=%b we=%b add=%h want 1 0 5",
               bus.grant, bus.mem_we, bus.mem_add);
    end
    tick();
    idle();
    #1;
    n_checks++;
    if (bus.sw_rdat !== 96'hA5) begin
      n_fail++;
      $display("FAIL sw_rd_data: got %h want a5", bus.sw_rdat);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      n_checks++;
      if (bus.sw_rdat !== 96'hA5) begin
        n_fail++;
        $display("FAIL sw_rd_hold%0d: got %h want a5",
                 i, bus.sw_rdat);
      end
    end
    tick();
  endtask

  // Expected: 8 HW acks, 1 grant, repeating.
  task automatic test_burst();
    logic eg;
    logic prev_hw;
    logic prev_sw;
    prev_hw = 1'b0;
    prev_sw = 1'b0;
    bus.hw_req = 1'b1;
    bus.hw_we  = 1'b0;
    bus.hw_add = 9'd7;
    bus.sw_cs  = 1'b1;
    bus.sw_we  = 1'b0;
    bus.sw_add = 9'd9;
    for (int i = 0; i < 20; i++) begin
      eg = ((i % 9) == 8);
      #1;
      n_checks++;
      if (bus.grant !== eg || bus.hw_ack !== !eg) begin
        n_fail++;
        $display("FAIL burst%0d: g=%b a=%b want %b %b",
                 i, bus.grant, bus.hw_ack, eg, !eg);
      end
      n_checks++;
      if (bus.hw_rvalid !== prev_hw ||
          bus.hw_rdat !== (prev_hw ? 96'h777 : 96'h0)) begin
        n_fail++;
        $display("FAIL burst_rv%0d: rv=%b d=%h want %b",
                 i, bus.hw_rvalid, bus.hw_rdat, prev_hw);
      end
      if (prev_sw) begin
        n_checks++;
        if (bus.sw_rdat !== 96'h999) begin
          n_fail++;
          $display("FAIL burst_sw%0d: got %h want 999",
                   i, bus.sw_rdat);
        end
      end
      prev_hw = !eg;
      prev_sw = eg;
      tick();
    end
  endtask

  task automatic test_yield();
    bus.sw_yield = 1'b1;
    #1;
    n_checks++;
    if (bus.grant !== 1'b1 || bus.hw_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL yield: g=%b a=%b want 1 0",
               bus.grant, bus.hw_ack);
    end
    tick();
    idle();
    tick();
  endtask

  task automatic test_sw_reset();
    int gcnt;
    int acnt;
    gcnt = 0;
    acnt = 0;
    bus.sw_reset = 1'b1;
    bus.hw_req   = 1'b1;
    bus.hw_we    = 1'b0;
    bus.hw_add   = 9'd7;
    for (int a = 0; a < 512; a++) begin
      bus.sw_cs   = 1'b1;
      bus.sw_we   = 1'b1;
      bus.sw_add  = 9'(a);
      bus.sw_wdat = 96'(a) + 96'h100;
      #1;
      if (bus.grant === 1'b1) gcnt++;
      if (bus.hw_ack === 1'b1) acnt++;
      tick();
    end
    bus.sw_reset = 1'b0;
    bus.sw_cs    = 1'b0;
    bus.sw_we    = 1'b0;
    #1;
    n_checks++;
    if (gcnt !== 512 || acnt !== 0) begin
      n_fail++;
      $display("FAIL swrst_cnt: grants=%0d acks=%0d want 512 0",
               gcnt, acnt);
    end
    n_checks++;
    if (bus.hw_ack !== 1'b1) begin
      n_fail++;
      $display("FAIL swrst_resume: ack=%b want 1", bus.hw_ack);
    end
    tick();
    idle();
    #1;
    n_checks++;
    if (bus.hw_rvalid !== 1'b1 || bus.hw_rdat !== 96'h107) begin
      n_fail++;
      $display("FAIL swrst_rd: rv=%b d=%h want 1 107",
               bus.hw_rvalid, bus.hw_rdat);
    end
    tick();
  endtask

  task automatic test_hw_write_sw_read();
    bus.hw_req  = 1'b1;
    bus.hw_we   = 1'b1;
    bus.hw_add  = 9'd3;
    bus.hw_wdat = 96'h1234;
    #1;
    n_checks++;
    if (bus.hw_ack !== 1'b1 || bus.mem_we !== 1'b1 ||
        bus.mem_add !== 9'd3 || bus.mem_wdat !== 96'h1234) begin
      n_fail++;
      $display("FAIL hw_wr: a=%b we=%b add=%h d=%h want 1 1 3 1234",
               bus.hw_ack, bus.mem_we, bus.mem_add, bus.mem_wdat);
    end
    tick();
    idle();
    bus.sw_cs  = 1'b1;
    bus.sw_add = 9'd3;
    #1;
    n_checks++;
    if (bus.grant !== 1'b1) begin
      n_fail++;
      $display("FAIL raw_grant: g=%b want 1", bus.grant);
    end
    tick();
    bus.sw_we   = 1'b1;
    bus.sw_add  = 9'd4;
    bus.sw_wdat = 96'hBEEF;
    #1;
    n_checks++;
    if (bus.sw_rdat !== 96'h1234 || bus.grant !== 1'b1) begin
      n_fail++;
      $display("FAIL raw_data: d=%h g=%b want 1234 1",
               bus.sw_rdat, bus.grant);
    end
    tick();
    idle();
    #1;
    n_checks++;
    if (bus.sw_rdat !== 96'h1234) begin
      n_fail++;
      $display("FAIL wr_keep: got %h want 1234", bus.sw_rdat);
    end
    n_checks++;
    if (bus.mem_cs !== 1'b0 || bus.mem_we !== 1'b0 ||
        bus.mem_add !== '0 || bus.mem_wdat !== '0) begin
      n_fail++;
      $display("FAIL idle_bus: cs=%b we=%b add=%h d=%h want 0",
               bus.mem_cs, bus.mem_we, bus.mem_add, bus.mem_wdat);
    end
    tick();
  endtask

  task automatic test_reset_inflight();
    bus.hw_req = 1'b1;
    bus.hw_we  = 1'b0;
    bus.hw_add = 9'd7;
    #1;
    n_checks++;
    if (bus.hw_ack !== 1'b1) begin
      n_fail++;
      $display("FAIL inflt_ack: got %b want 1", bus.hw_ack);
    end
    tick();
    rst_n      = 1'b0;
    bus.sw_cs  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (bus.hw_rvalid !== 1'b0 || bus.hw_rdat !== '0 ||
          bus.grant !== 1'b0 || bus.hw_ack !== 1'b0 ||
          bus.mem_cs !== 1'b0 || bus.sw_rdat !== '0) begin
        n_fail++;
        $display("FAIL inflt_rst%0d: rv=%b g=%b a=%b cs=%b sw=%h",
                 i, bus.hw_rvalid, bus.grant, bus.hw_ack,
                 bus.mem_cs, bus.sw_rdat);
      end
      tick();
    end
    idle();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (bus.hw_rvalid !== 1'b0) begin
        n_fail++;
        $display("FAIL inflt_post%0d: rv=%b want 0",
                 i, bus.hw_rvalid);
      end
      tick();
    end
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    bus.mem_rdat  = '0;
    idle();
    test_reset();
    test_first_cycle();
    test_sw_read();
    test_burst();
    test_yield();
    test_sw_reset();
    test_hw_write_sw_read();
    test_reset_inflight();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/nx_indirect_mem_arb.md
NX_INDIRECT_MEM_ARB -- requirements
Module: nx_indirect_mem_arb

Interface
REQ-001 Parameters SHALL be: N_ADDR_BITS, 9, RAM address width; N_DATA_BITS, 96, RAM data width; MAX_HW_BURST, 8, consecutive HW grants allowed while SW waits (range 1..255).
REQ-002 clk  input  1  clock; all logic on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 sw_cs  input  1  SW request from the indirect-access controller, held until granted.
REQ-005 sw_we  input  1  SW write (1) / read (0), valid with sw_cs.
REQ-006 sw_add, sw_wdat  input  N_ADDR_BITS, N_DATA_BITS  SW address and write data, valid with sw_cs.
REQ-007 sw_yield  input  1  SW starvation flag; forces SW priority.
REQ-008 sw_reset  input  1  SW table reset/init in progress; blocks HW.
REQ-009 grant  output  1  SW request accepted and RAM access issued this cycle.
REQ-010 sw_rdat  output  N_DATA_BITS  SW read data, valid from grant+1 until the next SW read is granted.
REQ-011 hw_req, hw_we  input  1, 1  HW request and write/read select.
REQ-012 hw_add, hw_wdat  input  N_ADDR_BITS, N_DATA_BITS  HW address and write data.
REQ-013 hw_ack  output  1  HW request accepted this cycle; HW may change its request next cycle.
REQ-014 hw_rvalid, hw_rdat  output  1, N_DATA_BITS  HW read return, exactly one cycle after the hw_ack of a read.
REQ-015 mem_cs, mem_we  output  1, 1  RAM chip select and write enable.
REQ-016 mem_add, mem_wdat  output  N_ADDR_BITS, N_DATA_BITS  RAM address and write data.
REQ-017 mem_rdat  input  N_DATA_BITS  RAM read data, fixed one-cycle latency after mem_cs with mem_we=0.

Function
REQ-018 At most one of grant and hw_ack SHALL be high in any cycle; mem_cs = grant | hw_ack.
REQ-019 grant and hw_ack SHALL be combinational from the current requests and the registered arbiter state, so that acceptance occurs in the cycle the request is seen.
REQ-020 The mem_* outputs SHALL carry the winner's we/add/wdat; when neither wins, mem_we = 0 and add/wdat = 0.
REQ-021 Priority, highest first: sw_reset & sw_cs -> SW; sw_yield & sw_cs -> SW; burst_cnt == MAX_HW_BURST & sw_cs -> SW; hw_req & !sw_reset -> HW; sw_cs -> SW.
REQ-022 hw_ack SHALL be 0 whenever sw_reset = 1, regardless of sw_cs.
REQ-023 burst_cnt (8 bits) SHALL increment on each hw_ack while sw_cs = 1, saturate at MAX_HW_BURST, and clear on grant or when sw_cs = 0.
REQ-024 A registered read-return flag SHALL mark the source of each RAM read (SW, HW, or none) and be used in the cycle after acceptance.
REQ-025 hw_rvalid SHALL be high one cycle after a HW read hw_ack, with hw_rdat = mem_rdat in that cycle; hw_rdat = 0 in all other cycles.
REQ-026 One cycle after a SW read grant, sw_rdat SHALL equal mem_rdat. On that same edge mem_rdat SHALL be captured into a hold register, and sw_rdat SHALL present the hold value until the next SW read returns.
REQ-027 SW writes SHALL NOT change sw_rdat.
REQ-028 Back-to-back accesses SHALL be supported: one access per cycle, with no bubble between SW and HW or between reads and writes.
REQ-029 A write followed by a read of the same address in the next cycle SHALL return the new data; the RAM provides this, and the block SHALL add no forwarding.

Reset
REQ-030 While rst_n = 0: grant, hw_ack, hw_rvalid, mem_cs, mem_we = 0; mem_add, mem_wdat, hw_rdat, sw_rdat = 0; burst_cnt = 0; read-return flag = none.
REQ-031 Reset asserted with a read in flight SHALL discard the read; no hw_rvalid SHALL appear after deassertion.
REQ-032 The first cycle after deassertion SHALL arbitrate normally.

Structure
REQ-033 A shared package SHALL hold the read-source enum {RS_NONE, RS_SW, RS_HW} and the arbiter-decision enum.
REQ-034 The block SHALL be a single module with no sub-modules; the RAM is external.

Verification
REQ-035 Idle, then SW read of address 5 with RAM[5] = 0xA5 -> grant in the same cycle; sw_rdat = 0xA5 at +1 and held for 10 idle cycles.
REQ-036 hw_req read and sw_cs both high continuously, MAX_HW_BURST = 8 -> 8 hw_ack cycles, then 1 grant, then HW resumes; never both high in one cycle.
REQ-037 sw_yield = 1 with hw_req and sw_cs high -> grant in that cycle, hw_ack = 0.
REQ-038 sw_reset = 1 with sw_cs write sweep over addresses 0..511 and hw_req high -> 512 grants, zero hw_ack; HW is acked on the first cycle after sw_reset drops.
REQ-039 HW writes 0x1234 to address 3, then SW reads address 3 in the next cycle -> sw_rdat = 0x1234.
REQ-040 rst_n dropped in the cycle after a HW read ack -> hw_rvalid never asserts; all outputs are 0 while in reset.
